// File: rtl/bcd_arb_pkg.sv
// Shared types and defaults for the BCD converter arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents: FSM state encoding (3 bit), default widths, and a helper
// that turns a decimal digit count into a packed-BCD bus width.
package bcd_arb_pkg;

  localparam int DEF_N_REQ  = 3;
  localparam int DEF_BIN_W  = 16;
  localparam int DEF_DIGITS = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CLEAR   = 3'd4
  } arb_state_t;

  // Four bits per decimal digit.
  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

  localparam int DEF_BCD_W = bcd_width(DEF_DIGITS);

endpackage

// File: rtl/bcd_conv_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping at N.
// Latency: purely combinational, no registers.
// Backpressure: none; gnt_vld is low when no request is set.
//
// Ports:
//   req      in   N    request vector
//   ptr      in   IW   highest-priority index, must be < N
//   gnt_oh   out  N    one-hot winner (all zero when gnt_vld=0)
//   gnt_idx  out  IW   winner index
//   gnt_vld  out  1    at least one request set
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  always_comb begin
    int cand;
    cand    = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    // Walk the ring starting at ptr; the first hit wins.
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!gnt_vld && req[IW'(cand)]) begin
        gnt_vld             = 1'b1;
        gnt_idx             = IW'(cand);
        gnt_oh[IW'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one binary-to-BCD converter among N_REQ requesters, round-robin.
// Latency: REQ in IDLE at t -> CONV_INIT at t+1; ACK one cycle after CONV_DONE is seen.
// Backpressure: REQ is a level held until ACK; one job in flight, others wait in IDLE.
//
// Optional feature macro: BCD_ARB_TIMEOUT_EN (WAIT watchdog, TIMEOUT_CYC cycles).
// Ports:
//   CLK, RST_N              clock, async active-low reset
//   REQ[N_REQ], BIN_IN      requests and flattened operands (slice i = BIN_IN[i*BIN_W +: BIN_W])
//   GNT, ACK                one-hot grant (grant..CLEAR), one-cycle ACK with valid BCD_OUT
//   BCD_OUT, BUSY, ERR      held result, not-IDLE flag, timeout pulse with ACK
//   CONV_BIN/INIT/CLR       converter operand, start pulse, return-to-start pulse
//   CONV_DONE, CONV_BCD     converter done level and result
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int BIN_W       = DEF_BIN_W,
  parameter int BCD_W       = DEF_BCD_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*BIN_W-1:0] BIN_IN,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       ACK,
  output logic [BCD_W-1:0]       BCD_OUT,
  output logic                   BUSY,
  output logic                   ERR,
  output logic [BIN_W-1:0]       CONV_BIN,
  output logic                   CONV_INIT,
  output logic                   CONV_CLR,
  input  logic                   CONV_DONE,
  input  logic [BCD_W-1:0]       CONV_BCD
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    ptr_q, win_q;
  logic [N_REQ-1:0] gnt_q;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic             err_q;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [BIN_W-1:0] pick_bin;
  logic             tmo_hit;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req     (REQ),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Operand mux driven by the one-hot pick.
  always_comb begin
    pick_bin = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) pick_bin = BIN_IN[i*BIN_W +: BIN_W];
    end
  end

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt_q;

  // Held at zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 tmo_cnt_q <= '0;
    else if (state_q != ST_WAIT) tmo_cnt_q <= '0;
    else                         tmo_cnt_q <= tmo_cnt_q + CW'(1);
  end

  // Fires on the TIMEOUT_CYC-th WAIT cycle without done.
  assign tmo_hit = (state_q == ST_WAIT) && !CONV_DONE &&
                   (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pick_vld) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_WAIT;
      ST_WAIT:    if (CONV_DONE || tmo_hit) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_CLEAR;
      ST_CLEAR:   state_d = ST_IDLE;
      default:    state_d = ST_CLEAR;
    endcase
  end

  // Result is registered on the WAIT->CAPTURE edge so that BCD_OUT is
  // already valid during the CAPTURE cycle in which ACK is raised.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= '0;
      win_q <= '0;
      gnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q <= pick_oh;
            win_q <= pick_idx;
            bin_q <= pick_bin;
          end
        end
        ST_WAIT: begin
          if (CONV_DONE) begin
            bcd_q <= CONV_BCD;
            err_q <= 1'b0;
          end else if (tmo_hit) begin
            bcd_q <= '1;
            err_q <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          ptr_q <= (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
        end
        ST_CLEAR: begin
          gnt_q <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign GNT       = gnt_q;
  assign ACK       = (state_q == ST_CAPTURE) ? gnt_q : '0;
  assign ERR       = (state_q == ST_CAPTURE) && err_q;
  assign BCD_OUT   = bcd_q;
  assign CONV_BIN  = bin_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign CONV_INIT = (state_q == ST_LOAD);
  assign CONV_CLR  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: reset, directed vector table,
// reset mid-job, randomized jobs against a round-robin model, optional timeout.
// A behavioural converter stub answers CONV_INIT after a programmable delay.
module tb_bcd_conv_arbiter;

  localparam int N   = 3;
  localparam int BW  = 16;
  localparam int CW  = 20;
  localparam int TMO = 8;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [N-1:0]    REQ;
  logic [N*BW-1:0] BIN_IN;
  logic [N-1:0]    GNT, ACK;
  logic [CW-1:0]   BCD_OUT;
  logic            BUSY, ERR;
  logic [BW-1:0]   CONV_BIN;
  logic            CONV_INIT, CONV_CLR;
  logic            CONV_DONE = 1'b0;
  logic [CW-1:0]   CONV_BCD;

  always #5 CLK = ~CLK;

  bcd_conv_arbiter #(.N_REQ(N), .BIN_W(BW), .BCD_W(CW), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .BIN_IN(BIN_IN),
    .GNT(GNT), .ACK(ACK), .BCD_OUT(BCD_OUT), .BUSY(BUSY), .ERR(ERR),
    .CONV_BIN(CONV_BIN), .CONV_INIT(CONV_INIT), .CONV_CLR(CONV_CLR),
    .CONV_DONE(CONV_DONE), .CONV_BCD(CONV_BCD)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Decimal digits by plain arithmetic.
  function automatic logic [CW-1:0] to_bcd(input logic [BW-1:0] v);
    int x;
    logic [CW-1:0] r;
    x = int'(v);
    r = '0;
    for (int d = 0; d < CW/4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Converter stub: done goes high stub_dly+1 cycles after init (never if <0).
  int            stub_dly = 0;
  int            stub_cnt = 0;
  logic          stub_busy = 1'b0;
  logic [BW-1:0] stub_op = '0;

  always @(posedge CLK) begin
    if (CONV_CLR) begin
      CONV_DONE <= 1'b0;
      stub_busy <= 1'b0;
    end else if (CONV_INIT) begin
      stub_busy <= 1'b1;
      stub_cnt  <= stub_dly;
      stub_op   <= CONV_BIN;
    end else if (stub_busy && !CONV_DONE && stub_dly >= 0) begin
      if (stub_cnt == 0) CONV_DONE <= 1'b1;
      else               stub_cnt  <= stub_cnt - 1;
    end
  end

  assign CONV_BCD = CONV_DONE ? to_bcd(stub_op) : '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Called at an IDLE negedge. Drives the job, then checks the LOAD and first WAIT cycles.
  task automatic start_job(input string nm, input logic [N-1:0] req, input logic [N*BW-1:0] bin,
                           input int dly, input int exp_idx, input bit scr_req);
    logic [BW-1:0] op;
    op       = bin[exp_idx*BW +: BW];
    REQ      = req;
    BIN_IN   = bin;
    stub_dly = dly;
    @(negedge CLK);
    chk({nm, "_init"}, 32'(CONV_INIT), 1);
    chk({nm, "_conv_bin"}, 32'(CONV_BIN), 32'(op));
    chk({nm, "_gnt_load"}, 32'(GNT), 32'(1) << exp_idx);
    // Operand and request changes after the grant must not affect the job.
    BIN_IN = ~bin;
    if (scr_req) REQ = N'($urandom_range(0, (1 << N) - 1));
    @(negedge CLK);
    chk({nm, "_init_off"}, 32'(CONV_INIT), 0);
    chk({nm, "_bin_hold"}, 32'(CONV_BIN), 32'(op));
  endtask

  // Waits for ACK, checks result, then the CLEAR and following IDLE cycle.
  task automatic finish_job(input string nm, input int exp_idx, input logic [CW-1:0] exp_bcd,
                            input logic exp_err, output int waited);
    waited = 0;
    while (ACK == '0 && waited < 300) begin
      @(negedge CLK);
      waited++;
    end
    if (ACK == '0) begin
      chk({nm, "_ack_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_ack"}, 32'(ACK), 32'(1) << exp_idx);
    chk({nm, "_gnt"}, 32'(GNT), 32'(1) << exp_idx);
    chk({nm, "_bcd"}, 32'(BCD_OUT), 32'(exp_bcd));
    chk({nm, "_err"}, 32'(ERR), 32'(exp_err));
    @(negedge CLK);
    chk({nm, "_clr"}, 32'(CONV_CLR), 1);
    chk({nm, "_ack_off"}, 32'(ACK), 0);
    @(negedge CLK);
    chk({nm, "_clr_once"}, 32'(CONV_CLR), 0);
    chk({nm, "_idle"}, {30'd0, BUSY, |GNT}, 0);
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic [N*BW-1:0] bin;
    int              dly;
    int              exp_idx;
    logic [CW-1:0]   exp_bcd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, mptr, waited;
    logic [N-1:0]    rq;
    logic [N*BW-1:0] bin;

    // Pointer starts at 0 for the table (after the mid-job reset).
    tbl[0] = '{3'b111, {16'd333, 16'd22, 16'd1},       2, 0, 20'h00001};
    tbl[1] = '{3'b111, {16'd333, 16'd22, 16'd1},       2, 1, 20'h00022};
    tbl[2] = '{3'b111, {16'd333, 16'd22, 16'd1},       2, 2, 20'h00333};
    tbl[3] = '{3'b111, {16'd333, 16'd22, 16'd1},       2, 0, 20'h00001};
    tbl[4] = '{3'b101, {16'd42, 16'd0, 16'd9999},      0, 2, 20'h00042};
    tbl[5] = '{3'b110, {16'd65534, 16'd1000, 16'd5},   1, 1, 20'h01000};
    tbl[6] = '{3'b011, {16'd0, 16'd7, 16'd65535},      4, 0, 20'h65535};
    tbl[7] = '{3'b001, {16'd0, 16'd0, 16'd10},         3, 0, 20'h00010};
    tbl[8] = '{3'b010, {16'd0, 16'd0, 16'd0},          1, 1, 20'h00000};

    // Reset state.
    RST_N = 1'b0;
    REQ = '0;
    BIN_IN = '0;
    repeat (3) @(negedge CLK);
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_ack", 32'(ACK), 0);
    chk("rst_bcd", 32'(BCD_OUT), 0);
    chk("rst_conv_bin", 32'(CONV_BIN), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_clr", 32'(CONV_CLR), 1);
    chk("rst_busy", 32'(BUSY), 1);
    chk("rst_init", 32'(CONV_INIT), 0);
    RST_N = 1'b1;
    #1 chk("rel_clr", 32'(CONV_CLR), 1);
    @(negedge CLK);
    chk("rel_idle", {30'd0, BUSY, CONV_CLR}, 0);

    // Single request, slow converter.
    start_job("single", 3'b001, {16'd0, 16'd0, 16'd255}, 20, 0, 1'b0);
    finish_job("single", 0, 20'h00255, 1'b0, waited);

    // Maximum operand.
    start_job("max", 3'b010, {16'd0, 16'hFFFF, 16'd0}, 3, 1, 1'b0);
    finish_job("max", 1, 20'h65535, 1'b0, waited);

    // Asynchronous reset while WAIT: everything back to reset values at once.
    start_job("rstwait", 3'b100, {16'd1234, 16'd0, 16'd0}, -1, 2, 1'b0);
    repeat (3) @(negedge CLK);
    chk("rstwait_busy_pre", 32'(BUSY), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("rstwait_gnt", 32'(GNT), 0);
    chk("rstwait_ack", 32'(ACK), 0);
    chk("rstwait_bcd", 32'(BCD_OUT), 0);
    chk("rstwait_conv_bin", 32'(CONV_BIN), 0);
    chk("rstwait_clr", 32'(CONV_CLR), 1);
    REQ = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rstwait_rel_clr", 32'(CONV_CLR), 1);
    chk("rstwait_rel_ack", 32'(ACK), 0);
    @(negedge CLK);
    chk("rstwait_idle", {29'd0, BUSY, CONV_CLR, |ACK}, 0);

    // Directed vector table.
    mptr = 0;
    for (int i = 0; i < 9; i++) begin
      start_job($sformatf("tbl%0d", i), tbl[i].req, tbl[i].bin, tbl[i].dly, tbl[i].exp_idx, 1'b0);
      finish_job($sformatf("tbl%0d", i), tbl[i].exp_idx, tbl[i].exp_bcd, 1'b0, waited);
      mptr = (tbl[i].exp_idx + 1) % N;
    end

    // Randomized jobs vs. round-robin model.
    for (int j = 0; j < 40; j++) begin
      rq  = N'($urandom_range(1, (1 << N) - 1));
      bin = {16'($urandom), 16'($urandom), 16'($urandom)};
      if (j % 7 == 0) bin[0 +: BW] = 16'hFFFF;
      w = -1;
      for (int off = 0; off < N; off++) begin
        if (w < 0 && rq[(mptr + off) % N]) w = (mptr + off) % N;
      end
      start_job($sformatf("rnd%0d", j), rq, bin, int'($urandom_range(0, 4)), w, 1'b1);
      finish_job($sformatf("rnd%0d", j), w, to_bcd(bin[w*BW +: BW]), 1'b0, waited);
      mptr = (w + 1) % N;
    end

`ifdef BCD_ARB_TIMEOUT_EN
    // Converter never finishes: watchdog ends WAIT after TMO cycles.
    start_job("tmo", 3'b001, {16'd0, 16'd0, 16'd77}, -1, 0, 1'b0);
    finish_job("tmo", 0, 20'hFFFFF, 1'b1, waited);
    chk("tmo_wait_cycles", 32'(waited), TMO);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
